uart_rx: RTL and testbench
==========================

# uart_rx

UART receive block, the counterpart of the team's UART-Tx frame serializer. It samples an asynchronous serial line using a 16x (parameterizable) oversampling tick and recovers start, data (7 or 8 bits, LSB first), optional parity and 1 or 2 stop bits. It presents the received byte with one-cycle valid and error flags. It sits between the pad-side serial input and the system-side receive FIFO/consumer, sharing the baud generator with the transmitter.

## Interface
- OVERSAMPLE, 16, baud_tick pulses per bit period; even, >= 8
- SYNC_STAGES, 2, metastability flops on rx_in
- clock  in  1  system clock; all logic on posedge
- rst  in  1  synchronous, active-low reset (sampled on posedge clock)
- baud_tick  in  1  one-clock enable at OVERSAMPLE x baud rate
- rx_in  in  1  asynchronous serial line, idle high
- parity_type  in  2  00 none, 01 odd, 10 even, 11 none
- stop_bits  in  1  0: one stop bit, 1: two stop bits
- data_length  in  1  0: 7 data bits, 1: 8 data bits
- data_out  out  8  received data; bit 7 forced 0 in 7-bit mode
- data_valid  out  1  one-clock pulse, frame complete
- parity_error  out  1  valid with data_valid; 0 when parity disabled
- frame_error  out  1  valid with data_valid; any stop sample was 0
- rx_active  out  1  high from start detect until frame end
- rx_done  out  1  high when idle/not receiving (complement of rx_active)

## Operation
- rx_in passes through SYNC_STAGES flops; all decisions use the synchronized value.
- States: IDLE, START, DATA, PARITY, STOP, DONE. State advances only on baud_tick except DONE -> IDLE, which takes one clock.
- IDLE: on a baud_tick with synchronized line 0, clear the tick counter, latch parity_type/stop_bits/data_length, and go to START. Config changes mid-frame have no effect.
- START: sample at tick count OVERSAMPLE/2-1. If the sample is 1, treat it as a glitch and go to IDLE with no flags. If 0, go to DATA.
- DATA: sample every OVERSAMPLE ticks at mid-bit, shifting LSB first into the data register. After 7 or 8 bits, go to PARITY if parity_type is 01/10, else go to STOP.
- PARITY: sample one bit. Odd: the XOR of data bits and the parity bit must be 1. Even: it must be 0. A mismatch sets parity_error.
- STOP: sample 1 or 2 bits. Any 0 sample sets frame_error (break condition included). After the last stop sample, go to DONE.
- DONE: drive data_out and the flags, pulse data_valid for one clock, then go to IDLE. A new start edge is searched from the next baud_tick.
- Counters: tick counter is log2(OVERSAMPLE) bits and wraps; bit counter is 3 bits and saturates at the frame end.

## Timing
- Reset (rst=0 at posedge): state IDLE, data_out=0, data_valid=0, parity_error=0, frame_error=0, rx_active=0, rx_done=1, synchronizer flops=1.
- Reset mid-frame aborts immediately with no data_valid. The partial frame is discarded.
- Let T0 be the detecting tick. Bit n (start=0) is sampled at T0 + OVERSAMPLE/2 - 1 + n*OVERSAMPLE ticks.
- 8N1 at 16x: the last stop sample falls at T0+151. data_valid is asserted the clock after that tick.
- Input latency: SYNC_STAGES clocks from a rx_in edge to visibility.
- data_out and the flags hold their values until the next data_valid. The flags are cleared at the next START entry.
- rx_active rises the clock after start detect. It falls in the same clock as data_valid, or on glitch rejection.
- A line low at the first IDLE tick after DONE is a valid back-to-back start.

## Structure
- Package uart_pkg holds:
  - state enum
  - parity encodings PARITY_NONE0=00, PARITY_ODD=01, PARITY_EVEN=10, PARITY_NONE1=11
  - default OVERSAMPLE
- The package is shared with the transmitter.
- Sub-module uart_rx_sync contains the SYNC_STAGES synchronizer, reset to 1.
- The FSM, counters and shift register stay in uart_rx.

## Test plan
- 8N1, byte 0xA5 -> data_out=0xA5, data_valid one clock at T0+151 ticks+1 clock, both errors 0.
- 7E2, data 0x55, parity bit 0 -> data_out=0x55, parity_error=0. The same frame with parity bit 1 -> parity_error=1.
- Low pulse of 4 ticks on an idle line -> return to IDLE, no data_valid, rx_active pulse only.
- 8O1, byte 0x00 with stop bit 0 -> data_valid=1, frame_error=1, data_out=0x00.
- Two back-to-back 8N1 frames 0x3C, 0xC3 with no idle gap -> two data_valid pulses with the correct bytes.
- rst=0 asserted at data bit 4 -> all outputs at reset values next clock. The next full frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, parity encodings and default oversampling.
package uart_pkg;

    localparam int unsigned OVERSAMPLE_DEFAULT = 16;

    localparam logic [1:0] PARITY_NONE0 = 2'b00;
    localparam logic [1:0] PARITY_ODD   = 2'b01;
    localparam logic [1:0] PARITY_EVEN  = 2'b10;
    localparam logic [1:0] PARITY_NONE1 = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StDone
    } rx_state_e;

    function automatic logic parity_enabled(input logic [1:0] parity_type);
        return (parity_type == PARITY_ODD) || (parity_type == PARITY_EVEN);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer for the asynchronous serial line; resets to the idle level (1).
module uart_rx_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clock,
    input  logic i_rst,
    input  logic i_async,
    output logic o_sync
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge i_clock) begin
        if (!i_rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= (r_sync << 1) | SYNC_STAGES'(i_async);
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/parity/stop recovery with one-cycle valid and error flags.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE  = OVERSAMPLE_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       i_clock,
    input  logic       i_rst,
    input  logic       i_baud_tick,
    input  logic       i_rx_in,
    input  logic [1:0] i_parity_type,
    input  logic       i_stop_bits,
    input  logic       i_data_length,
    output logic [7:0] o_data_out,
    output logic       o_data_valid,
    output logic       o_parity_error,
    output logic       o_frame_error,
    output logic       o_rx_active,
    output logic       o_rx_done
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

    rx_state_e r_state;
    rx_state_e w_state_d;

    logic          w_rx;
    logic [TW-1:0] r_tick;
    logic [TW-1:0] w_tick_inc;
    logic          w_sample;
    logic [2:0]    r_bit;
    logic          w_last_data;
    logic          w_last_stop;
    logic [7:0]    r_shift;
    logic [7:0]    w_data_bits;
    logic          w_par_bad;
    logic          w_start_entry;
    logic          w_done_entry;

    logic [1:0]    r_cfg_parity;
    logic          r_cfg_stop;
    logic          r_cfg_len;
    logic          r_perr;
    logic          r_ferr;

    logic [7:0]    r_data_out;
    logic          r_parity_error;
    logic          r_frame_error;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .i_clock(i_clock),
        .i_rst  (i_rst),
        .i_async(i_rx_in),
        .o_sync (w_rx)
    );

    // The tick value is judged after its increment, so the detecting tick counts as 0.
    assign w_tick_inc  = (r_tick == TICK_LAST) ? '0 : r_tick + 1'b1;
    assign w_sample    = i_baud_tick && (w_tick_inc == TICK_MID);
    assign w_last_data = (r_bit == (r_cfg_len ? 3'd7 : 3'd6));
    assign w_last_stop = !r_cfg_stop || (r_bit == 3'd1);
    assign w_data_bits = r_cfg_len ? r_shift : {1'b0, r_shift[7:1]};
    assign w_par_bad   = ((^w_data_bits) ^ w_rx) != (r_cfg_parity == PARITY_ODD);

    always_ff @(posedge i_clock) begin
        if (!i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (i_baud_tick && !w_rx) begin
                    w_state_d = StStart;
                end
            end
            StStart: begin
                if (w_sample) begin
                    w_state_d = w_rx ? StIdle : StData;
                end
            end
            StData: begin
                if (w_sample && w_last_data) begin
                    w_state_d = parity_enabled(r_cfg_parity) ? StParity : StStop;
                end
            end
            StParity: begin
                if (w_sample) begin
                    w_state_d = StStop;
                end
            end
            StStop: begin
                if (w_sample && w_last_stop) begin
                    w_state_d = StDone;
                end
            end
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    assign w_start_entry = (r_state == StIdle) && (w_state_d == StStart);
    assign w_done_entry  = (r_state == StStop) && (w_state_d == StDone);

    always_ff @(posedge i_clock) begin
        if (!i_rst) begin
            r_tick         <= '0;
            r_bit          <= '0;
            r_shift        <= '0;
            r_cfg_parity   <= PARITY_NONE0;
            r_cfg_stop     <= 1'b0;
            r_cfg_len      <= 1'b1;
            r_perr         <= 1'b0;
            r_ferr         <= 1'b0;
            r_data_out     <= '0;
            r_parity_error <= 1'b0;
            r_frame_error  <= 1'b0;
        end else begin
            if (i_baud_tick) begin
                r_tick <= (r_state == StIdle) ? '0 : w_tick_inc;
            end
            if (w_start_entry) begin
                r_cfg_parity   <= i_parity_type;
                r_cfg_stop     <= i_stop_bits;
                r_cfg_len      <= i_data_length;
                r_bit          <= '0;
                r_perr         <= 1'b0;
                r_ferr         <= 1'b0;
                r_parity_error <= 1'b0;
                r_frame_error  <= 1'b0;
            end
            if (w_sample) begin
                unique case (r_state)
                    StData: begin
                        r_shift <= {w_rx, r_shift[7:1]};
                        r_bit   <= w_last_data ? 3'd0 : r_bit + 3'd1;
                    end
                    StParity: r_perr <= w_par_bad;
                    StStop: begin
                        r_ferr <= r_ferr | !w_rx;
                        r_bit  <= (r_bit == 3'd7) ? r_bit : r_bit + 3'd1;
                    end
                    default: ;
                endcase
            end
            // Results include the final stop sample, which is taken in this same cycle.
            if (w_done_entry) begin
                r_data_out     <= w_data_bits;
                r_parity_error <= r_perr;
                r_frame_error  <= r_ferr | !w_rx;
            end
        end
    end

    assign o_data_out     = r_data_out;
    assign o_parity_error = r_parity_error;
    assign o_frame_error  = r_frame_error;
    assign o_data_valid   = (r_state == StDone);
    assign o_rx_active    = (r_state == StStart) || (r_state == StData) ||
                            (r_state == StParity) || (r_state == StStop);
    assign o_rx_done      = !o_rx_active;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frames driven tick-accurately, results checked via a scoreboard.
module tb_uart_rx;

    localparam int unsigned OS       = 16;
    localparam int unsigned TICK_DIV = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       baud_tick = 1'b0;
    logic       rx_in = 1'b1;
    logic [1:0] parity_type = 2'b00;
    logic       stop_bits = 1'b0;
    logic       data_length = 1'b1;
    logic [7:0] data_out;
    logic       data_valid, parity_error, frame_error, rx_active, rx_done;

    int n_checks = 0;
    int n_fail = 0;
    int n_frames = 0;
    int div_cnt = 0;
    int cyc = 0;
    int tick_num = 0;
    int last_tick_cyc = -10;
    int active_cycles = 0;
    int valid_cycles = 0;
    int done_bad = 0;

    logic [7:0] obs_data [32];
    logic       obs_perr [32];
    logic       obs_ferr [32];
    int         obs_tick [32];
    bit         obs_al   [32];
    int         obs_cnt = 0;
    int         rd_idx = 0;
    logic [9:0] exp_q [$];

    uart_rx #(
        .OVERSAMPLE (OS),
        .SYNC_STAGES(2)
    ) dut (
        .i_clock      (clk),
        .i_rst        (rst_n),
        .i_baud_tick  (baud_tick),
        .i_rx_in      (rx_in),
        .i_parity_type(parity_type),
        .i_stop_bits  (stop_bits),
        .i_data_length(data_length),
        .o_data_out   (data_out),
        .o_data_valid (data_valid),
        .o_parity_error(parity_error),
        .o_frame_error(frame_error),
        .o_rx_active  (rx_active),
        .o_rx_done    (rx_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (div_cnt == TICK_DIV - 1) begin
            div_cnt   <= 0;
            baud_tick <= 1'b1;
        end else begin
            div_cnt   <= div_cnt + 1;
            baud_tick <= 1'b0;
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (baud_tick) begin
            tick_num      <= tick_num + 1;
            last_tick_cyc <= cyc;
        end
    end

    always @(negedge clk) begin
        if (rx_active) active_cycles <= active_cycles + 1;
        if (rx_done === rx_active) done_bad <= done_bad + 1;
        if (data_valid) begin
            valid_cycles <= valid_cycles + 1;
            if (obs_cnt < 32) begin
                obs_data[obs_cnt] <= data_out;
                obs_perr[obs_cnt] <= parity_error;
                obs_ferr[obs_cnt] <= frame_error;
                obs_tick[obs_cnt] <= tick_num;
                obs_al[obs_cnt]   <= (last_tick_cyc == cyc - 1);
                obs_cnt           <= obs_cnt + 1;
            end
        end
    end

    task automatic wait_tick();
        @(posedge clk);
        while (!baud_tick) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) wait_tick();
    endtask

    task automatic send_bit(input logic b, input int n);
        rx_in = b;
        repeat (n) wait_tick();
    endtask

    // Drives one frame starting right after a tick; config is scrambled once the start is detected.
    task automatic send_frame(input logic [7:0] d, input logic len8, input logic [1:0] pt,
                              input logic two_stop, input logic flip_par, input logic stop_val,
                              output int t0);
        logic [7:0] dm;
        logic       par_en, pbit;
        int         nbits;
        nbits       = len8 ? 8 : 7;
        dm          = len8 ? d : {1'b0, d[6:0]};
        par_en      = (pt == 2'b01) || (pt == 2'b10);
        pbit        = ((pt == 2'b01) ? ~(^dm) : (^dm)) ^ flip_par;
        exp_q.push_back({dm, par_en & flip_par, ~stop_val});
        n_frames++;
        parity_type = pt;
        stop_bits   = two_stop;
        data_length = len8;
        rx_in = 1'b0;
        wait_tick();
        t0 = tick_num;
        parity_type = ~pt;
        stop_bits   = ~two_stop;
        data_length = ~len8;
        repeat (OS - 1) wait_tick();
        for (int i = 0; i < nbits; i++) send_bit(d[i], OS);
        if (par_en) send_bit(pbit, OS);
        if (two_stop) send_bit(1'b1, OS);
        if (stop_val) send_bit(1'b1, OS);
        else send_bit(1'b0, OS / 2);
        rx_in = 1'b1;
    endtask

    task automatic get_obs(output bit ok, output logic [9:0] got, output int tk, output bit al);
        int n;
        n = 0;
        ok = 0; got = '0; tk = 0; al = 0;
        while (obs_cnt <= rd_idx && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (obs_cnt > rd_idx) begin
            ok  = 1;
            got = {obs_data[rd_idx], obs_perr[rd_idx], obs_ferr[rd_idx]};
            tk  = obs_tick[rd_idx];
            al  = obs_al[rd_idx];
            rd_idx++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({data_out, data_valid, parity_error, frame_error, rx_active, rx_done} !== 13'h001) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want %h",
                     {data_out, data_valid, parity_error, frame_error, rx_active, rx_done}, 13'h001);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_8n1();
        int t0, tk, a0;
        bit ok, al;
        logic [9:0] got, exp;
        idle(4);
        a0 = active_cycles;
        send_frame(8'hA5, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, t0);
        get_obs(ok, got, tk, al);
        exp = exp_q.pop_front();
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL 8n1_valid: got none want 1 pulse"); end
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL 8n1_data: got %h want %h", got, exp); end
        n_checks++;
        if (tk !== t0 + 151) begin n_fail++; $display("FAIL 8n1_tick: got %0d want %0d", tk, t0 + 151); end
        n_checks++;
        if (al !== 1'b1) begin n_fail++; $display("FAIL 8n1_clock_after_tick: got %0d want 1", al); end
        n_checks++;
        if (active_cycles - a0 !== 151 * TICK_DIV) begin
            n_fail++;
            $display("FAIL 8n1_active_len: got %0d want %0d", active_cycles - a0, 151 * TICK_DIV);
        end
    endtask

    task automatic test_7e2();
        int t0, tk;
        bit ok, al;
        logic [9:0] got, exp;
        for (int f = 0; f < 2; f++) begin
            idle(4);
            send_frame(8'h55, 1'b0, 2'b10, 1'b1, f[0], 1'b1, t0);
            get_obs(ok, got, tk, al);
            exp = exp_q.pop_front();
            n_checks++;
            if (!ok || got !== exp) begin
                n_fail++;
                $display("FAIL 7e2_flip%0d: got %h (ok=%0d) want %h", f, got, ok, exp);
            end
        end
    endtask

    task automatic test_glitch();
        int c0, a0;
        idle(4);
        c0 = obs_cnt;
        a0 = active_cycles;
        send_bit(1'b0, 4);
        idle(24);
        n_checks++;
        if (obs_cnt !== c0) begin n_fail++; $display("FAIL glitch_valid: got %0d want 0", obs_cnt - c0); end
        n_checks++;
        if (active_cycles - a0 !== 7 * TICK_DIV) begin
            n_fail++;
            $display("FAIL glitch_active: got %0d want %0d", active_cycles - a0, 7 * TICK_DIV);
        end
    endtask

    task automatic test_8o1_break();
        int t0, tk;
        bit ok, al;
        logic [9:0] got, exp;
        idle(4);
        send_frame(8'h00, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, t0);
        get_obs(ok, got, tk, al);
        exp = exp_q.pop_front();
        n_checks++;
        if (!ok || got !== exp) begin
            n_fail++;
            $display("FAIL 8o1_break: got %h (ok=%0d) want %h", got, ok, exp);
        end
        idle(16);
        n_checks++;
        if (frame_error !== 1'b1) begin n_fail++; $display("FAIL ferr_hold: got %b want 1", frame_error); end
        send_bit(1'b0, 2);
        n_checks++;
        if ({rx_active, frame_error} !== 2'b10) begin
            n_fail++;
            $display("FAIL ferr_clear_on_start: got %b want 10", {rx_active, frame_error});
        end
        idle(24);
    endtask

    task automatic test_back_to_back();
        int t0, t1, tk;
        bit ok, al;
        logic [9:0] got, exp;
        idle(4);
        send_frame(8'h3C, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, t0);
        send_frame(8'hC3, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, t1);
        for (int f = 0; f < 2; f++) begin
            get_obs(ok, got, tk, al);
            exp = exp_q.pop_front();
            n_checks++;
            if (!ok || got !== exp) begin
                n_fail++;
                $display("FAIL b2b_frame%0d: got %h (ok=%0d) want %h", f, got, ok, exp);
            end
        end
        n_checks++;
        if (t1 - t0 !== 10 * OS) begin n_fail++; $display("FAIL b2b_gap: got %0d want %0d", t1 - t0, 10 * OS); end
    endtask

    task automatic test_reset_midframe();
        int c0, t0, tk;
        bit ok, al;
        logic [9:0] got, exp;
        logic [7:0] d;
        d = 8'h81;
        idle(4);
        parity_type = 2'b00; stop_bits = 1'b0; data_length = 1'b1;
        send_bit(1'b0, OS);
        for (int i = 0; i < 4; i++) send_bit(d[i], OS);
        send_bit(d[4], OS / 2);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if ({data_out, data_valid, parity_error, frame_error, rx_active, rx_done} !== 13'h001) begin
            n_fail++;
            $display("FAIL midframe_reset: got %h want %h",
                     {data_out, data_valid, parity_error, frame_error, rx_active, rx_done}, 13'h001);
        end
        rst_n = 1'b1;
        c0 = obs_cnt;
        idle(12 * OS);
        n_checks++;
        if (obs_cnt !== c0) begin n_fail++; $display("FAIL midframe_discard: got %0d want 0", obs_cnt - c0); end
        send_frame(d, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, t0);
        get_obs(ok, got, tk, al);
        exp = exp_q.pop_front();
        n_checks++;
        if (!ok || got !== exp) begin
            n_fail++;
            $display("FAIL after_reset_frame: got %h (ok=%0d) want %h", got, ok, exp);
        end
    endtask

    task automatic test_end();
        idle(8);
        n_checks++;
        if (valid_cycles !== n_frames) begin
            n_fail++;
            $display("FAIL valid_pulses: got %0d want %0d", valid_cycles, n_frames);
        end
        n_checks++;
        if (done_bad !== 0) begin n_fail++; $display("FAIL rx_done_complement: got %0d want 0", done_bad); end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_7e2();
        test_glitch();
        test_8o1_break();
        test_back_to_back();
        test_reset_midframe();
        test_end();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
